pll_rst_seq: RTL and testbench

- Supervises an iCE40 UltraPlus PLL_B and generates staggered reset releases for the fabric.
- Runs on the free-running HSOSC reference clock, never the PLL output, so it keeps operating when the PLL loses lock.
- Drives the PLL's active-low `RESET_N` and debounces the PLL `LOCK` output.
- Retries acquisition on lock timeout or lock loss, and latches a fault after a bounded number of retries.

---
 rtl/pll_rst_pkg.sv | 25 ++
 rtl/sync_2ff.sv | 27 ++
 rtl/pll_rst_seq.sv | 197 +++++++++++++++++++
 tb/tb_pll_rst_seq.sv | 225 ++++++++++++++++++++++
 4 files changed

// File: rtl/pll_rst_pkg.sv
// Shared types and helpers for the PLL supervisor / staggered reset sequencer.
// Latency: n/a (types and constant functions only).
// Backpressure: n/a.
package pll_rst_pkg;

  typedef enum logic [2:0] {
    PLL_RESET   = 3'd0,
    WAIT_LOCK   = 3'd1,
    LOCK_STABLE = 3'd2,
    RELEASE     = 3'd3,
    RUN         = 3'd4,
    FAULT       = 3'd5
  } state_t;

  // One counter serves every timed phase, so it must hold the largest terminal count.
  function automatic int cnt_width(input int a, input int b, input int c, input int d);
    int m;
    m = a;
    if (b > m) m = b;
    if (c > m) m = c;
    if (d > m) m = d;
    return $clog2(m + 1);
  endfunction

endpackage

// File: rtl/sync_2ff.sv
// Two-flop synchronizer for signals crossing into the clk domain.
// Latency: 2 clk edges from input change to output change.
// Backpressure: none; level signals only.
module sync_2ff #(
  parameter int               WIDTH   = 1,
  parameter logic [WIDTH-1:0] RST_VAL = '0
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [WIDTH-1:0] d,
  output logic [WIDTH-1:0] q
);

  logic [WIDTH-1:0] meta;

  // First flop may go metastable; second flop gives it a full cycle to resolve.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      meta <= RST_VAL;
      q    <= RST_VAL;
    end else begin
      meta <= d;
      q    <= meta;
    end
  end

endmodule

// File: rtl/pll_rst_seq.sv
// PLL_B supervisor: pulses RESET_N, qualifies LOCK, retries, then releases fabric resets in index order.
// Latency: lock fall to all resets asserted in 3 clk edges; outputs registered and aligned with state.
// Backpressure: none; soft_rst/clr_fault are single-cycle synchronous requests, honoured only in their states.
module pll_rst_seq
  import pll_rst_pkg::*;
#(
  parameter  int NUM_RST             = 3,
  parameter  int PLL_RST_CYCLES      = 16,
  parameter  int LOCK_STABLE_CYCLES  = 1024,
  parameter  int LOCK_TIMEOUT_CYCLES = 65536,
  parameter  int STAGGER_CYCLES      = 8,
  parameter  int MAX_RETRIES         = 3,
  localparam int RW                  = (MAX_RETRIES > 0) ? $clog2(MAX_RETRIES + 1) : 1
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               pll_lock,
  input  logic               soft_rst,
  input  logic               clr_fault,
  output logic               pll_rst_n,
  output logic [NUM_RST-1:0] rst_out,
  output logic               ready,
  output logic               fault,
  output logic [RW-1:0]      retries,
  output logic [2:0]         state
);

  localparam int CW  = cnt_width(PLL_RST_CYCLES, LOCK_STABLE_CYCLES, LOCK_TIMEOUT_CYCLES,
                                 NUM_RST * STAGGER_CYCLES);
  localparam int CHW = (NUM_RST > 1) ? $clog2(NUM_RST) : 1;

  // Terminal counts: the counter starts at 0 on phase entry, so a phase of N edges ends at N-1.
  localparam logic [CW-1:0]  PLL_RST_LAST = CW'(PLL_RST_CYCLES - 1);
  localparam logic [CW-1:0]  STABLE_LAST  = CW'(LOCK_STABLE_CYCLES - 1);
  localparam logic [CW-1:0]  TIMEOUT_LAST = CW'(LOCK_TIMEOUT_CYCLES - 1);
  localparam logic [CW-1:0]  STAGGER_LAST = CW'(STAGGER_CYCLES - 1);
  localparam logic [CHW-1:0] CH_LAST      = CHW'(NUM_RST - 1);
  localparam logic [RW-1:0]  RETRY_MAX    = RW'(MAX_RETRIES);

  state_t             state_q, state_nxt;
  logic [CW-1:0]      cnt_q, cnt_nxt;
  logic [CHW-1:0]     ch_q, ch_nxt;
  logic [RW-1:0]      retries_nxt;
  logic               rel_step;
  logic               restart;
  logic               lock_s;
  logic               pll_rst_n_nxt;
  logic [NUM_RST-1:0] rst_out_nxt;
  logic               ready_nxt;
  logic               fault_nxt;

  sync_2ff #(.WIDTH(1), .RST_VAL(1'b0)) u_lock_sync (
    .clk (clk),
    .rst (rst),
    .d   (pll_lock),
    .q   (lock_s)
  );

  // State register plus the shared cycle counter, channel index and retry count.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= PLL_RESET;
      cnt_q   <= '0;
      ch_q    <= '0;
      retries <= '0;
    end else begin
      state_q <= state_nxt;
      cnt_q   <= cnt_nxt;
      ch_q    <= ch_nxt;
      retries <= retries_nxt;
    end
  end

  // Next-state and counter update; lock loss outranks soft_rst in the released states.
  always_comb begin
    state_nxt   = state_q;
    cnt_nxt     = cnt_q;
    ch_nxt      = ch_q;
    retries_nxt = retries;
    rel_step    = 1'b0;
    restart     = 1'b0;
    case (state_q)
      PLL_RESET: begin
        if (cnt_q == PLL_RST_LAST) begin
          state_nxt = WAIT_LOCK;
          cnt_nxt   = '0;
        end else begin
          cnt_nxt = cnt_q + 1'b1;
        end
      end
      WAIT_LOCK: begin
        if (lock_s) begin
          state_nxt = LOCK_STABLE;
          cnt_nxt   = '0;
        end else if (cnt_q == TIMEOUT_LAST) begin
          cnt_nxt = '0;
          if (retries == RETRY_MAX) begin
            state_nxt = FAULT;
          end else begin
            state_nxt   = PLL_RESET;
            retries_nxt = retries + 1'b1;
          end
        end else begin
          cnt_nxt = cnt_q + 1'b1;
        end
      end
      LOCK_STABLE: begin
        if (!lock_s) begin
          // A glitch is not a failed acquisition: fresh timeout, no retry charged.
          state_nxt = WAIT_LOCK;
          cnt_nxt   = '0;
        end else if (cnt_q == STABLE_LAST) begin
          state_nxt = RELEASE;
          cnt_nxt   = '0;
          ch_nxt    = '0;
        end else begin
          cnt_nxt = cnt_q + 1'b1;
        end
      end
      RELEASE, RUN: begin
        if (!lock_s) begin
          cnt_nxt = '0;
          ch_nxt  = '0;
          if (retries == RETRY_MAX) begin
            state_nxt = FAULT;
          end else begin
            state_nxt   = PLL_RESET;
            retries_nxt = retries + 1'b1;
          end
        end else if (soft_rst) begin
          state_nxt   = RELEASE;
          cnt_nxt     = '0;
          ch_nxt      = '0;
          retries_nxt = '0;
          restart     = 1'b1;
        end else if (state_q == RELEASE) begin
          if (cnt_q == STAGGER_LAST) begin
            rel_step = 1'b1;
            cnt_nxt  = '0;
            if (ch_q == CH_LAST) begin
              state_nxt = RUN;
            end else begin
              ch_nxt = ch_q + 1'b1;
            end
          end else begin
            cnt_nxt = cnt_q + 1'b1;
          end
        end
      end
      FAULT: begin
        if (clr_fault) begin
          state_nxt   = PLL_RESET;
          cnt_nxt     = '0;
          retries_nxt = '0;
        end
      end
      default: begin
        state_nxt = PLL_RESET;
        cnt_nxt   = '0;
        ch_nxt    = '0;
      end
    endcase
  end

  // Output values for the coming state, so registered outputs change on the same edge as the state.
  always_comb begin
    pll_rst_n_nxt = !((state_nxt == PLL_RESET) || (state_nxt == FAULT));
    ready_nxt     = (state_nxt == RUN);
    fault_nxt     = (state_nxt == FAULT);
    rst_out_nxt   = rst_out;
    if ((state_nxt != RELEASE && state_nxt != RUN) || restart) begin
      rst_out_nxt = '1;
    end else begin
      for (int k = 0; k < NUM_RST; k++) begin
        if (rel_step && (ch_q == CHW'(k))) rst_out_nxt[k] = 1'b0;
      end
    end
  end

  // Output registers; reset holds the PLL in reset and every channel asserted.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      pll_rst_n <= 1'b0;
      rst_out   <= '1;
      ready     <= 1'b0;
      fault     <= 1'b0;
    end else begin
      pll_rst_n <= pll_rst_n_nxt;
      rst_out   <= rst_out_nxt;
      ready     <= ready_nxt;
      fault     <= fault_nxt;
    end
  end

  assign state = state_q;

endmodule

// File: tb/tb_pll_rst_seq.sv
// Directed bench for pll_rst_seq with short timing parameters.
// Latency: n/a.
// Backpressure: n/a.
module tb_pll_rst_seq;

  logic       clk = 1'b0;
  logic       rst = 1'b0;
  logic       pll_lock = 1'b0;
  logic       soft_rst = 1'b0;
  logic       clr_fault = 1'b0;
  logic       pll_rst_n;
  logic [2:0] rst_out;
  logic       ready;
  logic       fault;
  logic [1:0] retries;
  logic [2:0] state;

  int tests = 0;
  int failed = 0;

  localparam logic [2:0] S_PLL_RESET = 3'd0;
  localparam logic [2:0] S_WAIT_LOCK = 3'd1;
  localparam logic [2:0] S_LOCK_STAB = 3'd2;
  localparam logic [2:0] S_RELEASE   = 3'd3;
  localparam logic [2:0] S_RUN       = 3'd4;
  localparam logic [2:0] S_FAULT     = 3'd5;

  pll_rst_seq #(
    .NUM_RST             (3),
    .PLL_RST_CYCLES      (4),
    .LOCK_STABLE_CYCLES  (8),
    .LOCK_TIMEOUT_CYCLES (32),
    .STAGGER_CYCLES      (2),
    .MAX_RETRIES         (2)
  ) dut (
    .clk       (clk),
    .rst       (rst),
    .pll_lock  (pll_lock),
    .soft_rst  (soft_rst),
    .clr_fault (clr_fault),
    .pll_rst_n (pll_rst_n),
    .rst_out   (rst_out),
    .ready     (ready),
    .fault     (fault),
    .retries   (retries),
    .state     (state)
  );

  always #5 clk = ~clk;

  task automatic tick(input int n);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    tests++;
    assert (obs === exp) else begin
      failed++;
      $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
    end
  endtask

  task automatic chk_all(input string tag, input logic e_pll, input logic [2:0] e_rst,
                         input logic e_rdy, input logic e_flt, input logic [1:0] e_ret,
                         input logic [2:0] e_st);
    chk({tag, ".pll_rst_n"}, 32'(pll_rst_n), 32'(e_pll));
    chk({tag, ".rst_out"},   32'(rst_out),   32'(e_rst));
    chk({tag, ".ready"},     32'(ready),     32'(e_rdy));
    chk({tag, ".fault"},     32'(fault),     32'(e_flt));
    chk({tag, ".retries"},   32'(retries),   32'(e_ret));
    chk({tag, ".state"},     32'(state),     32'(e_st));
  endtask

  initial begin
    // Reset values, asynchronously before any clock edge, then held across edges.
    #1 rst = 1'b1;
    #1 chk_all("reset_async", 1'b0, 3'b111, 1'b0, 1'b0, 2'd0, S_PLL_RESET);
    tick(2);
    chk_all("reset_held", 1'b0, 3'b111, 1'b0, 1'b0, 2'd0, S_PLL_RESET);
    rst = 1'b0;

    // Cold start: PLL reset 4 edges, lock at cycle 10, 8 stable, releases every 2.
    tick(3);
    chk("cold.pll_low_e3", 32'(pll_rst_n), 32'd0);
    tick(1);
    chk_all("cold.e4", 1'b1, 3'b111, 1'b0, 1'b0, 2'd0, S_WAIT_LOCK);
    tick(5);
    pll_lock = 1'b1;
    tick(2);
    chk("cold.wait_e11", 32'(state), 32'(S_WAIT_LOCK));
    tick(1);
    chk("cold.stable_e12", 32'(state), 32'(S_LOCK_STAB));
    tick(7);
    chk_all("cold.e19", 1'b1, 3'b111, 1'b0, 1'b0, 2'd0, S_LOCK_STAB);
    tick(1);
    chk_all("cold.e20", 1'b1, 3'b111, 1'b0, 1'b0, 2'd0, S_RELEASE);
    tick(1);
    chk("cold.rst_e21", 32'(rst_out), 32'b111);
    tick(1);
    chk("cold.rst_e22", 32'(rst_out), 32'b110);
    tick(1);
    chk("cold.rst_e23", 32'(rst_out), 32'b110);
    tick(1);
    chk("cold.rst_e24", 32'(rst_out), 32'b100);
    tick(1);
    chk("cold.ready_e25", 32'(ready), 32'd0);
    tick(1);
    chk_all("cold.e26", 1'b1, 3'b000, 1'b1, 1'b0, 2'd0, S_RUN);

    // Lock loss in RUN: resets reassert on the third edge, one retry charged.
    pll_lock = 1'b0;
    tick(2);
    chk_all("loss.a2", 1'b1, 3'b000, 1'b1, 1'b0, 2'd0, S_RUN);
    tick(1);
    chk_all("loss.a3", 1'b0, 3'b111, 1'b0, 1'b0, 2'd1, S_PLL_RESET);
    tick(3);
    chk("loss.pll_low_a6", 32'(pll_rst_n), 32'd0);
    tick(1);
    chk_all("loss.a7", 1'b1, 3'b111, 1'b0, 1'b0, 2'd1, S_WAIT_LOCK);
    pll_lock = 1'b1;
    tick(3);
    chk("loss.stable", 32'(state), 32'(S_LOCK_STAB));
    tick(8);
    chk_all("loss.release", 1'b1, 3'b111, 1'b0, 1'b0, 2'd1, S_RELEASE);
    tick(6);
    chk_all("loss.rerun", 1'b1, 3'b000, 1'b1, 1'b0, 2'd1, S_RUN);

    // soft_rst in RUN: all channels reassert next edge, PLL untouched, retries cleared.
    soft_rst = 1'b1;
    tick(1);
    chk_all("soft.c1", 1'b1, 3'b111, 1'b0, 1'b0, 2'd0, S_RELEASE);
    soft_rst = 1'b0;
    tick(2);
    chk("soft.rst_c3", 32'(rst_out), 32'b110);
    tick(2);
    chk("soft.rst_c5", 32'(rst_out), 32'b100);
    tick(2);
    chk_all("soft.c7", 1'b1, 3'b000, 1'b1, 1'b0, 2'd0, S_RUN);

    // Async reset mid-RELEASE, between clock edges.
    soft_rst = 1'b1;
    tick(1);
    soft_rst = 1'b0;
    tick(4);
    chk_all("arst.before", 1'b1, 3'b100, 1'b0, 1'b0, 2'd0, S_RELEASE);
    #2 rst = 1'b1;
    #1 chk_all("arst.after", 1'b0, 3'b111, 1'b0, 1'b0, 2'd0, S_PLL_RESET);
    tick(2);
    rst = 1'b0;

    // Lock glitch during LOCK_STABLE: back to WAIT_LOCK, stable count restarts.
    tick(4);
    chk("glitch.wait_e4", 32'(state), 32'(S_WAIT_LOCK));
    tick(1);
    chk("glitch.stable_e5", 32'(state), 32'(S_LOCK_STAB));
    pll_lock = 1'b0;
    tick(1);
    pll_lock = 1'b1;
    tick(1);
    chk("glitch.stable_e7", 32'(state), 32'(S_LOCK_STAB));
    tick(1);
    chk_all("glitch.e8", 1'b1, 3'b111, 1'b0, 1'b0, 2'd0, S_WAIT_LOCK);
    tick(1);
    chk("glitch.stable_e9", 32'(state), 32'(S_LOCK_STAB));
    tick(4);
    chk_all("glitch.e13", 1'b1, 3'b111, 1'b0, 1'b0, 2'd0, S_LOCK_STAB);
    tick(3);
    chk("glitch.stable_e16", 32'(state), 32'(S_LOCK_STAB));
    tick(1);
    chk("glitch.release_e17", 32'(state), 32'(S_RELEASE));

    // No lock: three reset pulses at 36-cycle period, then FAULT.
    pll_lock = 1'b0;
    rst = 1'b1;
    tick(2);
    rst = 1'b0;
    tick(3);
    chk("tmo.pll_low_f3", 32'(pll_rst_n), 32'd0);
    tick(1);
    chk("tmo.pll_high_f4", 32'(pll_rst_n), 32'd1);
    tick(31);
    chk_all("tmo.f35", 1'b1, 3'b111, 1'b0, 1'b0, 2'd0, S_WAIT_LOCK);
    tick(1);
    chk_all("tmo.f36", 1'b0, 3'b111, 1'b0, 1'b0, 2'd1, S_PLL_RESET);
    tick(3);
    chk("tmo.pll_low_f39", 32'(pll_rst_n), 32'd0);
    tick(1);
    chk("tmo.pll_high_f40", 32'(pll_rst_n), 32'd1);
    tick(31);
    chk("tmo.pll_high_f71", 32'(pll_rst_n), 32'd1);
    tick(1);
    chk_all("tmo.f72", 1'b0, 3'b111, 1'b0, 1'b0, 2'd2, S_PLL_RESET);
    tick(4);
    chk("tmo.wait_f76", 32'(state), 32'(S_WAIT_LOCK));
    tick(31);
    chk_all("tmo.f107", 1'b1, 3'b111, 1'b0, 1'b0, 2'd2, S_WAIT_LOCK);
    tick(1);
    chk_all("tmo.fault", 1'b0, 3'b111, 1'b0, 1'b1, 2'd2, S_FAULT);
    tick(5);
    chk_all("tmo.fault_hold", 1'b0, 3'b111, 1'b0, 1'b1, 2'd2, S_FAULT);

    // clr_fault leaves FAULT, clears retries and restarts the PLL reset pulse.
    clr_fault = 1'b1;
    tick(1);
    chk_all("clr.g1", 1'b0, 3'b111, 1'b0, 1'b0, 2'd0, S_PLL_RESET);
    clr_fault = 1'b0;
    tick(4);
    chk("clr.wait_g5", 32'(state), 32'(S_WAIT_LOCK));
    chk("clr.pll_high_g5", 32'(pll_rst_n), 32'd1);

    // soft_rst has no effect outside RELEASE/RUN.
    soft_rst = 1'b1;
    tick(1);
    soft_rst = 1'b0;
    chk("soft_ignored.state", 32'(state), 32'(S_WAIT_LOCK));
    chk("soft_ignored.rst_out", 32'(rst_out), 32'b111);

    $display("[TB] %0d tests run, %0d failed", tests, failed);
    $finish;
  end

endmodule
